noc_merge_arbiter: RTL and testbench
====================================

NOC_MERGE_ARBITER -- requirements
Module: noc_merge_arbiter

Interface
REQ-001 Parameter: W, default 9, flit width; bits [W-1:W-4] carry the 4-bit destination address and bits [W-5:0] the payload.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in0_data  input  W  flit from requester 0.
REQ-005 in0_valid  input  1  requester 0 offers a flit.
REQ-006 in0_ready  output  1  requester 0 flit accepted this cycle.
REQ-007 in1_data / in1_valid / in1_ready  input/input/output  W/1/1  same as REQ-004 to REQ-006, for requester 1.
REQ-008 out_data  output  W  registered merged flit.
REQ-009 out_valid  output  1  out_data holds a flit.
REQ-010 out_ready  input  1  downstream consumes the flit.
REQ-011 sel  output  1  source (0 or 1) of the flit in out_data.
REQ-012 gcnt0, gcnt1  output  8  accepted-flit counters per requester.

Function
REQ-013 A transfer SHALL occur on any port where valid and ready are both 1 at a rising clk edge.
REQ-014 The output stage SHALL be a one-entry register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 The slot is free when the state is EMPTY, or when the state is FULL and out_ready=1.
REQ-016 inX_ready SHALL be 1 only for the granted requester, and only while the slot is free; at most one inX_ready is 1 per cycle.
REQ-017 With exactly one valid requester, that requester SHALL be granted.
REQ-018 With both requesters valid, the grant SHALL follow the Configuration rule.
REQ-019 An accepted flit SHALL appear on out_data with out_valid=1 on the next cycle (1-cycle latency), and sel SHALL equal its source.
REQ-020 Throughput SHALL be 1 flit/cycle: drain and load in the same cycle keep the state FULL with the new flit.
REQ-021 Transitions:
- EMPTY to FULL on accept.
- FULL to EMPTY on drain with no accept.
- FULL stays FULL on drain plus accept, or on no drain.
REQ-022 While FULL and out_ready=0, out_data, sel and out_valid SHALL hold stable.
REQ-023 No flit SHALL be dropped, duplicated or reordered per requester.
REQ-024 gcntX SHALL increment by 1 on each requester-X accept and wrap 255 to 0.
REQ-025 inX_data SHALL not be interpreted; the address field passes unchanged.

Reset
REQ-026 While rst_n=0, all state SHALL reset immediately, independent of clk, to:
- state EMPTY
- out_valid=0, out_data=0, sel=0
- gcnt0=gcnt1=0
- round-robin pointer = last-granted 1 (requester 0 wins the first contention)
REQ-027 While rst_n=0, in0_ready and in1_ready SHALL be 0.
REQ-028 A flit held in the output register when reset asserts SHALL be discarded.
REQ-029 After rst_n deasserts, the block SHALL accept a flit at the first rising clk edge.

Configuration
REQ-030 With RR_FAIR_EN defined, contention SHALL grant the requester not granted last.
REQ-031 With RR_FAIR_EN defined, the pointer SHALL update only on an actual accept.
REQ-032 Without RR_FAIR_EN, contention SHALL always grant requester 0 (fixed priority), and no pointer state SHALL exist.

Verification
REQ-033 Reset, then in0_valid=1 with in0_data=9'h155 and out_ready=1 -> in0_ready=1 in cycle 0; in cycle 1 out_valid=1, out_data=9'h155, sel=0, gcnt0=1.
REQ-034 Both requesters valid continuously, out_ready=1, RR_FAIR_EN defined -> sel sequence 0,1,0,1 at 1 flit/cycle; gcnt0=gcnt1=2 after 4 flits.
REQ-035 Same stimulus as REQ-034 without RR_FAIR_EN -> sel always 0 and in1_ready stays 0.
REQ-036 Output FULL with out_ready=0 for 5 cycles while both inputs are valid -> both readies stay 0 and out_data is unchanged; on out_ready=1 a new flit loads in the same cycle.
REQ-037 in1 sends 300 flits, out_ready=1 -> gcnt1=44 (wrap); data is in order with none lost.
REQ-038 rst_n=0 asserted mid-cycle while FULL -> out_valid=0 immediately, without waiting for a clk edge; after release, a fresh flit is accepted on the first edge.

Source files
------------

// File: rtl/noc_merge_arbiter.sv
// noc_merge_arbiter: merges two flit requesters into one registered output slot.
// Define RR_FAIR_EN for round-robin contention; without it requester 0 always wins.
module noc_merge_arbiter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sel,
    output logic [7:0]   gcnt0,
    output logic [7:0]   gcnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_out_data;
    logic         r_sel;
    logic [7:0]   r_gcnt0;
    logic [7:0]   r_gcnt1;

    logic         w_slot_free;
    logic         w_gnt0;
    logic         w_gnt1;
    logic         w_acc0;
    logic         w_acc1;
    logic         w_accept;

`ifdef RR_FAIR_EN
    logic         r_last_gnt;
`endif

    // rst_n gates the slot so both readies are low for the whole reset interval.
    assign w_slot_free = rst_n & ((r_state == EMPTY) | out_ready);

    always_comb begin
        // NOTE: give every combinational output a default first so no path infers a latch.
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (in0_valid && in1_valid) begin
`ifdef RR_FAIR_EN
            w_gnt0 = r_last_gnt;
            w_gnt1 = ~r_last_gnt;
`else
            w_gnt0 = 1'b1;
`endif
        end else begin
            w_gnt0 = in0_valid;
            w_gnt1 = in1_valid;
        end
    end

    assign in0_ready = w_slot_free & w_gnt0;
    assign in1_ready = w_slot_free & w_gnt1;
    assign w_acc0    = in0_valid & in0_ready;
    assign w_acc1    = in1_valid & in1_ready;
    assign w_accept  = w_acc0 | w_acc1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_out_data <= '0;
            r_sel      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                EMPTY:   if (w_accept) r_state <= FULL;
                FULL:    if (out_ready && !w_accept) r_state <= EMPTY;
                default: r_state <= EMPTY;
            endcase
            if (w_accept) begin
                r_out_data <= w_acc1 ? in1_data : in0_data;
                r_sel      <= w_acc1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gcnt0 <= 8'd0;
            r_gcnt1 <= 8'd0;
        end else begin
            if (w_acc0) r_gcnt0 <= r_gcnt0 + 8'd1;
            if (w_acc1) r_gcnt1 <= r_gcnt1 + 8'd1;
        end
    end

`ifdef RR_FAIR_EN
    // Reset value 1 lets requester 0 win the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
        end else if (w_accept) begin
            r_last_gnt <= w_acc1;
        end
    end
`endif

    assign out_data  = r_out_data;
    assign out_valid = (r_state == FULL);
    assign sel       = r_sel;
    assign gcnt0     = r_gcnt0;
    assign gcnt1     = r_gcnt1;

endmodule

// File: tb/tb_noc_merge_arbiter.sv
// Self-checking bench for noc_merge_arbiter: slot-level model plus per-requester scoreboard.
// Grant expectations follow RR_FAIR_EN when the bench is built with that macro.
module tb_noc_merge_arbiter;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic         in0_valid, in1_valid, in0_ready, in1_ready;
  logic         out_valid, out_ready, sel;
  logic [7:0]   gcnt0, gcnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  noc_merge_arbiter #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0_data (in0_data),
    .in0_valid(in0_valid),
    .in0_ready(in0_ready),
    .in1_data (in1_data),
    .in1_valid(in1_valid),
    .in1_ready(in1_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel      (sel),
    .gcnt0    (gcnt0),
    .gcnt1    (gcnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one slot, accept counts, last-granted source, and per-requester queues of accepted flits.
  bit           m_full;
  logic [W-1:0] m_data;
  bit           m_sel;
  bit           m_last;
  int           m_cnt[2];
  int           drained[2];
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  function automatic bit m_free();
    return rst_n && (!m_full || out_ready);
  endfunction

  function automatic int m_pick();
    if (in0_valid && in1_valid) begin
`ifdef RR_FAIR_EN
      return m_last ? 0 : 1;
`else
      return 0;
`endif
    end
    if (in0_valid) return 0;
    if (in1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full  = 1'b0;
      m_data  = '0;
      m_sel   = 1'b0;
      m_last  = 1'b1;
      m_cnt   = '{0, 0};
      drained = '{0, 0};
      q0.delete();
      q1.delete();
    end else begin
      int mg;
      mg = m_pick();
      if (m_free() && mg >= 0) begin
        m_full = 1'b1;
        m_sel  = (mg == 1);
        m_last = (mg == 1);
        m_data = (mg == 1) ? in1_data : in0_data;
        m_cnt[mg]++;
        if (mg == 1) q1.push_back(in1_data);
        else         q0.push_back(in0_data);
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Compare process: every falling edge, DUT against the model.
  always @(negedge clk) begin
    int cg;
    bit e0, e1;
    logic [W-1:0] exp_flit;
    cg = m_pick();
    e0 = m_free() && (cg == 0);
    e1 = m_free() && (cg == 1);
    check("in0_ready", in0_ready, e0);
    check("in1_ready", in1_ready, e1);
    check("out_valid", out_valid, m_full);
    if (m_full) begin
      check("out_data", out_data, m_data);
      check("sel", sel, m_sel);
    end
    check("gcnt0", gcnt0, m_cnt[0] % 256);
    check("gcnt1", gcnt1, m_cnt[1] % 256);
    if (rst_n && m_full && out_ready) begin
      if (m_sel) begin
        check("sb_q1_nonempty", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          exp_flit = q1.pop_front();
          check("sb_order_in1", out_data, exp_flit);
        end
      end else begin
        check("sb_q0_nonempty", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          exp_flit = q0.pop_front();
          check("sb_order_in0", out_data, exp_flit);
        end
      end
      drained[m_sel]++;
    end
  end

  // Stimulus helpers: all are entered and left at posedge+1.
  int   k0 = 0;
  int   k1 = 0;
  logic a0, a1;

  task automatic run_cycles(input int n, input logic v0, input logic v1, input logic ordy);
    for (int i = 0; i < n; i++) begin
      in0_valid = v0;
      in1_valid = v1;
      out_ready = ordy;
      @(negedge clk);
      a0 = in0_ready;
      a1 = in1_ready;
      @(posedge clk);
      #1;
      if (a0) begin
        k0++;
        in0_data = W'(64 + k0 * 5);
      end
      if (a1) begin
        k1++;
        in1_data = W'((k1 * 3) ^ 448);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v0;
    bit v1;
    bit ordy;
  } vec_t;

  vec_t tbl[12] = '{'{1, 1, 1}, '{1, 1, 0}, '{0, 1, 0}, '{0, 1, 1},
                    '{1, 0, 1}, '{0, 0, 1}, '{1, 1, 1}, '{1, 1, 1},
                    '{0, 0, 0}, '{1, 0, 0}, '{0, 1, 1}, '{0, 0, 1}};

  initial begin
    logic [W-1:0] hv0, hv1;
    rst_n     = 1'b0;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 9'h0AA;
    in1_data  = 9'h1C3;
    out_ready = 1'b1;

    // Reset state, with both requesters pushing.
    repeat (2) @(negedge clk);
    check("rst_in0_ready", in0_ready, 0);
    check("rst_in1_ready", in1_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sel", sel, 0);
    check("rst_gcnt0", gcnt0, 0);
    check("rst_gcnt1", gcnt1, 0);

    // Single flit, first edge after release, 1-cycle latency.
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in1_valid = 1'b0;
    in0_data  = 9'h155;
    @(negedge clk);
    check("single_in0_ready", in0_ready, 1);
    @(posedge clk);
    #1;
    in0_valid = 1'b0;
    check("single_out_valid", out_valid, 1);
    check("single_out_data", out_data, 9'h155);
    check("single_sel", sel, 0);
    check("single_gcnt0", gcnt0, 1);
    run_cycles(1, 0, 0, 1);

    // Continuous contention at full rate.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_cycles(1, 1, 1, 1);
`ifdef RR_FAIR_EN
      check("contend_sel", sel, i % 2);
      check("contend_in1_ready", a1, i % 2);
`else
      check("contend_sel", sel, 0);
      check("contend_in1_ready", a1, 0);
`endif
      check("contend_out_valid", out_valid, 1);
    end
`ifdef RR_FAIR_EN
    check("contend_gcnt0", gcnt0, 2);
    check("contend_gcnt1", gcnt1, 2);
`else
    check("contend_gcnt0", gcnt0, 4);
    check("contend_gcnt1", gcnt1, 0);
`endif

    // Backpressure: slot full, out_ready low for 5 cycles, then drain and load together.
    do_reset();
    hv0 = in0_data;
    run_cycles(1, 1, 1, 0);
    check("bp_load_valid", out_valid, 1);
    check("bp_load_data", out_data, hv0);
    for (int i = 0; i < 5; i++) begin
      run_cycles(1, 1, 1, 0);
      check("bp_in0_ready", a0, 0);
      check("bp_in1_ready", a1, 0);
      check("bp_hold_data", out_data, hv0);
      check("bp_hold_valid", out_valid, 1);
    end
    hv0 = in0_data;
    hv1 = in1_data;
    run_cycles(1, 1, 1, 1);
    check("bp_release_valid", out_valid, 1);
`ifdef RR_FAIR_EN
    check("bp_release_in1_ready", a1, 1);
    check("bp_release_sel", sel, 1);
    check("bp_release_data", out_data, hv1);
`else
    check("bp_release_in0_ready", a0, 1);
    check("bp_release_sel", sel, 0);
    check("bp_release_data", out_data, hv0);
`endif
    run_cycles(2, 0, 0, 1);

    // Mixed directed vectors, checked by the model.
    foreach (tbl[i]) run_cycles(1, tbl[i].v0, tbl[i].v1, tbl[i].ordy);
    run_cycles(3, 0, 0, 1);

    // Long in1 stream: counter wraps, nothing lost.
    do_reset();
    run_cycles(300, 0, 1, 1);
    check("stream_gcnt1_wrap", gcnt1, 44);
    run_cycles(1, 0, 0, 1);
    check("stream_drained", drained[1], 300);
    check("stream_sb_empty", q1.size(), 0);

    // Asynchronous reset while full, then a fresh flit on the first edge.
    do_reset();
    run_cycles(1, 1, 0, 0);
    check("areset_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 0);
    check("areset_in0_ready", in0_ready, 0);
    check("areset_gcnt0", gcnt0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    hv0   = in0_data;
    #1;
    check("areset_rel_ready", in0_ready, 1);
    @(posedge clk);
    #1;
    in0_valid = 1'b0;
    check("areset_fresh_valid", out_valid, 1);
    check("areset_fresh_data", out_data, hv0);
    check("areset_fresh_gcnt0", gcnt0, 1);
    run_cycles(2, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
